// File: rtl/systolic_matmul_engine_if.sv
// Streaming job interface of the systolic matrix-multiply engine.
// master: the NPU controller side; slave: the engine.
interface systolic_matmul_engine_if #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_WIDTH = 32,
  parameter int K_MAX        = 16
);
  localparam int KW = $clog2(K_MAX + 1);

  logic                                start;
  logic [KW-1:0]                       k_len;
  logic                                a_valid;
  logic [ROWS*DATA_WIDTH-1:0]          a_col;
  logic                                b_valid;
  logic [COLS*DATA_WIDTH-1:0]          b_row;
  logic                                a_ready;
  logic                                b_ready;
  logic                                busy;
  logic                                done;
  logic                                result_valid;
  logic [ROWS*COLS*RESULT_WIDTH-1:0]   result;

  modport master (
    output start, k_len, a_valid, a_col, b_valid, b_row,
    input  a_ready, b_ready, busy, done, result_valid, result
  );

  modport slave (
    input  start, k_len, a_valid, a_col, b_valid, b_row,
    output a_ready, b_ready, busy, done, result_valid, result
  );
endinterface

// File: rtl/systolic_matmul_engine.sv
// Output-stationary systolic engine computing C = A x B (ROWS x K by K x COLS).
// Unskewed A columns / B rows are skewed internally; each PE accumulates in place.
// Build option: define SYSTOLIC_SIGNED_EN for two's-complement operands
// (products sign-extended); otherwise operands are unsigned.
module systolic_matmul_engine #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_WIDTH = 32,
  parameter int K_MAX        = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  systolic_matmul_engine_if.slave  bus
);
  localparam int KW         = $clog2(K_MAX + 1);
  localparam int DRAIN_LAST = ROWS + COLS - 1;
  localparam int DCW        = $clog2(ROWS + COLS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  logic [KW-1:0]    r_k;
  logic [KW-1:0]    r_beat;
  logic [DCW-1:0]   r_drain;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_result_valid;

  logic             w_beat;
  logic             w_clear;
  logic [KW-1:0]    w_k_clamp;
  logic [DATA_WIDTH-1:0] w_a_in [ROWS][COLS];
  logic [DATA_WIDTH-1:0] w_b_in [ROWS][COLS];
  logic [ROWS*COLS*RESULT_WIDTH-1:0] w_result;

  assign w_beat    = (r_state == S_LOAD) && bus.a_valid && bus.b_valid;
  assign w_clear   = (r_state == S_IDLE) && bus.start;
  assign w_k_clamp = (bus.k_len > KW'(K_MAX)) ? KW'(K_MAX) : bus.k_len;

  // Job FSM with registered handshake/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_k            <= '0;
      r_beat         <= '0;
      r_drain        <= '0;
      r_ready        <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_k            <= w_k_clamp;
            r_beat         <= '0;
            r_busy         <= 1'b1;
            r_result_valid <= 1'b0;
            if (w_k_clamp == '0) begin
              // Empty job: jump to the last drain count so done lands one edge after start.
              r_state <= S_DRAIN;
              r_drain <= DCW'(DRAIN_LAST);
            end else begin
              r_state <= S_LOAD;
              r_ready <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (w_beat) begin
            if (r_beat == r_k - KW'(1)) begin
              r_state <= S_DRAIN;
              r_drain <= '0;
              r_ready <= 1'b0;
            end else begin
              r_beat <= r_beat + KW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (r_drain == DCW'(DRAIN_LAST)) begin
            r_state        <= S_DONE;
            r_done         <= 1'b1;
            r_result_valid <= 1'b1;
          end else begin
            r_drain <= r_drain + DCW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  genvar gi, gj;

  // Row skew: A element i is delayed i cycles behind the input capture stage.
  for (gi = 0; gi < ROWS; gi++) begin : g_a_skew
    logic [DATA_WIDTH-1:0] r_stage [0:gi];
    // Capture accepted A beats (zero on bubbles) and shift down the skew line.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s <= gi; s++) r_stage[s] <= '0;
      end else begin
        r_stage[0] <= w_beat ? bus.a_col[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int s = 1; s <= gi; s++) r_stage[s] <= r_stage[s-1];
      end
    end
    assign w_a_in[gi][0] = r_stage[gi];
  end

  // Column skew: B element j is delayed j cycles behind the input capture stage.
  for (gj = 0; gj < COLS; gj++) begin : g_b_skew
    logic [DATA_WIDTH-1:0] r_stage [0:gj];
    // Capture accepted B beats (zero on bubbles) and shift down the skew line.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s <= gj; s++) r_stage[s] <= '0;
      end else begin
        r_stage[0] <= w_beat ? bus.b_row[gj*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int s = 1; s <= gj; s++) r_stage[s] <= r_stage[s-1];
      end
    end
    assign w_b_in[0][gj] = r_stage[gj];
  end

  // PE grid: multiply-accumulate in place, pass A east and B south.
  for (gi = 0; gi < ROWS; gi++) begin : g_row
    for (gj = 0; gj < COLS; gj++) begin : g_pe
      logic [RESULT_WIDTH-1:0] r_acc;
      logic [RESULT_WIDTH-1:0] w_prod;
`ifdef SYSTOLIC_SIGNED_EN
      logic signed [2*DATA_WIDTH-1:0] w_full;
      assign w_full = $signed(w_a_in[gi][gj]) * $signed(w_b_in[gi][gj]);
`else
      logic [2*DATA_WIDTH-1:0] w_full;
      assign w_full = w_a_in[gi][gj] * w_b_in[gi][gj];
`endif
      assign w_prod = RESULT_WIDTH'(w_full);

      // Accumulator: cleared by an accepted start, otherwise wraps on overflow.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_acc <= '0;
        else if (w_clear) r_acc <= '0;
        else              r_acc <= r_acc + w_prod;
      end
      assign w_result[(gi*COLS+gj)*RESULT_WIDTH +: RESULT_WIDTH] = r_acc;

      if (gj < COLS - 1) begin : g_fwd_a
        logic [DATA_WIDTH-1:0] r_a;
        // Forward A operand to the east neighbour.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) r_a <= '0;
          else     r_a <= w_a_in[gi][gj];
        end
        assign w_a_in[gi][gj+1] = r_a;
      end

      if (gi < ROWS - 1) begin : g_fwd_b
        logic [DATA_WIDTH-1:0] r_b;
        // Forward B operand to the south neighbour.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) r_b <= '0;
          else     r_b <= w_b_in[gi][gj];
        end
        assign w_b_in[gi+1][gj] = r_b;
      end
    end
  end

  assign bus.a_ready      = r_ready;
  assign bus.b_ready      = r_ready;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.result_valid = r_result_valid;
  assign bus.result       = w_result;
endmodule

// File: doc/systolic_matmul_engine.md
# systolic_matmul_engine

Parametrised output-stationary systolic matrix-multiply engine, the next generation of the fixed 4x4 PE array in the NPU datapath. Computes C = A×B for A of ROWS×K and B of K×COLS, with K programmable per job up to K_MAX. Input skewing, a valid/ready streaming handshake, a job FSM and an exact done timing are integrated, so the NPU controller streams unskewed columns of A and rows of B and reads back the full C tile.

## Interface
- ROWS, 4: PE rows, ≥1
- COLS, 4: PE columns, ≥1
- DATA_WIDTH, 8: operand width
- RESULT_WIDTH, 32: accumulator/result width, ≥ 2*DATA_WIDTH
- K_MAX, 16: maximum inner dimension per job
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  job request, sampled only in IDLE
- k_len  in  $clog2(K_MAX+1)  inner dimension K, sampled with start
- a_valid  in  1  a_col beat valid
- a_col  in  ROWS*DATA_WIDTH  column k of A, element i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- b_valid  in  1  b_row beat valid
- b_row  in  COLS*DATA_WIDTH  row k of B, element j at bits [j*DATA_WIDTH +: DATA_WIDTH]
- a_ready  out  1  high in LOAD
- b_ready  out  1  high in LOAD
- busy  out  1  high in LOAD, DRAIN, DONE
- done  out  1  one-cycle pulse at job completion
- result_valid  out  1  C valid; held until next accepted start
- result  out  ROWS*COLS*RESULT_WIDTH  C[i][j] at bits [(i*COLS+j)*RESULT_WIDTH +: RESULT_WIDTH]

## Operation
- FSM: IDLE, LOAD, DRAIN, DONE.
- IDLE: start=1 clears all accumulators, clears result_valid, latches k_len clamped to K_MAX, and zeroes the beat counter. Goes to LOAD, or to DONE if the latched K = 0.
- LOAD: a beat is accepted only when a_valid && b_valid. A single valid is not consumed. After the K-th accepted beat, go to DRAIN.
- Bubble cycles inject zero operands into the array, so they do not affect any result.
- Skew: element i of a_col passes through i register stages before PE row i. Element j of b_row passes through j stages before PE column j.
- PE(i,j) each cycle:
  - acc += a_in*b_in
  - forwards a east and b south through one register each
- DRAIN: counts ROWS+COLS-1 cycles, then goes to DONE.
- DONE: done=1 for one cycle, result_valid set, go to IDLE.
- Arithmetic:
  - Each product is extended to RESULT_WIDTH.
  - Accumulation wraps modulo 2^RESULT_WIDTH, with no saturation.
- start while busy is ignored. a_valid/b_valid outside LOAD are ignored.
- result is driven directly from the accumulators. It is stable from DONE until the next accepted start.

## Timing
- Reset values: state IDLE, all accumulators 0, all skew/forward registers 0, every output 0 (result all zeros).
- start sampled at edge S. Beats may be accepted from edge S+1.
- A beat accepted at edge e is accumulated into PE(i,j) at edge e+1+i+j.
- If the last beat is accepted at edge E, done and result_valid rise at edge E+ROWS+COLS.
- With no bubbles, done rises at edge S+K+ROWS+COLS. For 4x4 with K=4 that is S+12.
- K = 0: done at edge S+1 with result all zeros.
- Reset asserted mid-job: immediate return to reset values; the partial job is discarded.
- Throughput: one beat per cycle. No new job starts until the cycle after done.

## Configuration
- SYSTOLIC_SIGNED_EN defined:
  - Operands are two's-complement signed.
  - Products are sign-extended to RESULT_WIDTH.
- Undefined:
  - Operands are unsigned.
  - Products are zero-extended.
- FSM, timing and interface are identical in both builds.

## Test plan
- 4x4, K=4, A=identity, B[k][j]=k*4+j+1, no bubbles: done exactly at S+12; C = B; done high exactly one cycle.
- 4x4, K=16, all operands 8'hFF, unsigned build: every C[i][j] = 1,040,400.
- K=3 with random a_valid/b_valid gaps, including cycles with only one valid high: result matches the reference model; done at the last-accepted-beat edge + 8.
- k_len=0: done at S+1, all results 0; start while busy is ignored and does not change the K latched for the running job.
- rst pulsed in DRAIN: all outputs return to 0 asynchronously; a following K=2 job produces the correct C with no residue.
- SYSTOLIC_SIGNED_EN build, K=2, A all -128, B all -128: every C[i][j] = 32768; A=-1, B=1 gives -2 (32'hFFFFFFFE).
